// File: rtl/sram_cmd_sequencer_if.sv
// System-side command/response channels of the SRAM command sequencer.
// master: the requester issuing commands and consuming read responses.
// slave : the sequencer accepting commands and producing read responses.
`timescale 1ns/1ps
interface sram_cmd_sequencer_if #(
    parameter int ROWS = 16,
    parameter int COLS = 8
);
    localparam int AW = $clog2(ROWS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [COLS-1:0] cmd_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_cmd_sequencer.sv
// Converts parallel read/write commands into the serial-load SRAM pin protocol.
// Writes: MSB-first serial shift (each bit held SHIFT_HOLD cycles), load pulse,
// one idle gap, then a w_en pulse. Reads: r_en pulse, wait for data_valid,
// capture data_out and hold it on the response channel until consumed.
// Optional build macro SRAM_SEQ_RD_TIMEOUT_EN bounds the read wait to
// RD_TIMEOUT cycles and reports an expired wait through rsp_err.
`timescale 1ns/1ps
module sram_cmd_sequencer #(
    parameter int ROWS       = 16,
    parameter int COLS       = 8,
    parameter int SHIFT_HOLD = 2
`ifdef SRAM_SEQ_RD_TIMEOUT_EN
    ,
    parameter int RD_TIMEOUT = 16
`endif
) (
    input  logic                    clk,
    input  logic                    arst_n,
    sram_cmd_sequencer_if.slave     bus,
    output logic                    wr_done,
    output logic                    serial_in,
    output logic                    shift,
    output logic                    load,
    output logic                    w_en,
    output logic                    r_en,
    output logic [$clog2(ROWS)-1:0] addr,
    input  logic                    data_valid,
    input  logic [COLS-1:0]         data_out
);
    localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HW = (SHIFT_HOLD > 1) ? $clog2(SHIFT_HOLD) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(COLS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SHIFT_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT, ST_LOAD, ST_GAP, ST_WRITE, ST_READ, ST_RD_WAIT, ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [COLS-1:0] shift_buf_q, shift_buf_d;
    logic [1:0]      rst_pipe;
    logic            rst_n;
    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [COLS-1:0] rsp_rdata_q;
    logic            accept;
    logic            in_read;
    logic            capture;
    logic            timeout_hit;

    assign accept  = bus.cmd_valid && cmd_ready_q;
    assign in_read = (state_q == ST_READ) || (state_q == ST_RD_WAIT);
    assign capture = in_read && data_valid;

    // Reset synchroniser: assertion takes effect at once, release is aligned to clk.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rst_pipe <= '0;
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // FSM state, bit/hold counters and the latched write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            hold_q      <= '0;
            shift_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            hold_q      <= hold_d;
            shift_buf_q <= shift_buf_d;
        end
    end

    // Next-state logic; pin values are derived from the next state and registered below.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        bit_d       = bit_q;
        hold_d      = hold_q;
        shift_buf_d = shift_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_buf_d = bus.cmd_wdata;
                    bit_d       = '0;
                    hold_d      = '0;
                    state_d     = bus.cmd_write ? ST_SHIFT : ST_READ;
                end
            end
            ST_SHIFT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (bit_q == BIT_LAST) state_d = ST_LOAD;
                    else                   bit_d   = bit_q + BW'(1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_LOAD:  state_d = ST_GAP;
            ST_GAP:   state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_READ, ST_RD_WAIT: begin
                if (capture || timeout_hit) state_d = ST_RESP;
                else                        state_d = ST_RD_WAIT;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered pins and response data, so SRAM-side outputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done     <= 1'b0;
            serial_in   <= 1'b0;
            shift       <= 1'b0;
            load        <= 1'b0;
            w_en        <= 1'b0;
            r_en        <= 1'b0;
            addr        <= '0;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            shift       <= (state_d == ST_SHIFT);
            serial_in   <= (state_d == ST_SHIFT) ? shift_buf_d[BIT_LAST - bit_d] : 1'b0;
            load        <= (state_d == ST_LOAD);
            w_en        <= (state_d == ST_WRITE);
            wr_done     <= (state_d == ST_WRITE);
            r_en        <= (state_d == ST_READ);
            if (accept)           addr        <= bus.cmd_addr;
            if (capture)          rsp_rdata_q <= data_out;
            else if (timeout_hit) rsp_rdata_q <= '1;
        end
    end

`ifdef SRAM_SEQ_RD_TIMEOUT_EN
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    logic [TW-1:0] to_q;
    logic          err_q;

    // The r_en cycle counts as wait cycle 1; data_valid in the expiring cycle still wins.
    assign timeout_hit = in_read && !data_valid && (to_q == TW'(RD_TIMEOUT));

    // Read-wait counter and sticky error flag, cleared by the next accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                to_q  <= TW'(1);
                err_q <= 1'b0;
            end else if (in_read) begin
                to_q <= to_q + TW'(1);
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Directed bench for sram_cmd_sequencer with a behavioural serial-load SRAM.
// The SRAM model samples serial_in once per held bit, loads on load, writes on
// w_en and answers r_en with data_valid two cycles later (unless muted).
`timescale 1ns/1ps
module tb_sram_cmd_sequencer;
    localparam int ROWS  = 16;
    localparam int COLS  = 8;
    localparam int SH    = 2;
    localparam int AW    = $clog2(ROWS);
    localparam int W_CYC = COLS * SH + 4;
`ifdef SRAM_SEQ_RD_TIMEOUT_EN
    localparam int RD_TIMEOUT = 16;
`endif

    logic            clk    = 1'b0;
    logic            arst_n = 1'b0;
    logic            serial_in, shift, load, w_en, r_en, wr_done;
    logic [AW-1:0]   addr;
    logic            data_valid;
    logic [COLS-1:0] data_out;

    sram_cmd_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    sram_cmd_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .SHIFT_HOLD(SH)
`ifdef SRAM_SEQ_RD_TIMEOUT_EN
        , .RD_TIMEOUT(RD_TIMEOUT)
`endif
    ) dut (
        .clk(clk), .arst_n(arst_n), .bus(bus), .wr_done(wr_done),
        .serial_in(serial_in), .shift(shift), .load(load), .w_en(w_en),
        .r_en(r_en), .addr(addr), .data_valid(data_valid), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_done) wr_cnt <= wr_cnt + 1;
    end

    // SRAM behavioural model
    logic [COLS-1:0] mem [ROWS];
    logic [COLS-1:0] shreg, stage;
    int              sc;
    logic [1:0]      dv_sr;
    logic            mute     = 1'b0;
    logic            mem_init = 1'b0;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sc    <= 0;
            dv_sr <= '0;
            shreg <= '0;
            stage <= '0;
            if (!mem_init) begin
                for (int i = 0; i < ROWS; i++) mem[i] <= (i == 5) ? 8'h3C : 8'h00;
                mem_init <= 1'b1;
            end
        end else begin
            if (shift) begin
                sc <= sc + 1;
                if (sc % SH == SH - 1) shreg <= {shreg[COLS-2:0], serial_in};
            end else begin
                sc <= 0;
            end
            if (load) stage <= shreg;
            if (w_en) mem[addr] <= stage;
            dv_sr <= {dv_sr[0], r_en && !mute};
        end
    end
    assign data_valid = dv_sr[1];
    assign data_out   = data_valid ? mem[addr] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {shift, serial_in, load, w_en, wr_done, r_en, rsp_valid, cmd_ready}
    function automatic logic [7:0] pins();
        return {shift, serial_in, load, w_en, wr_done, r_en, bus.rsp_valid, bus.cmd_ready};
    endfunction

    // Expected pins c cycles after a write accept, data sent MSB first.
    function automatic logic [7:0] exp_wr(input int c, input logic [COLS-1:0] d);
        logic [7:0] v;
        v = 8'h00;
        if (c >= 1 && c <= COLS * SH) begin
            v[7] = 1'b1;
            v[6] = d[COLS - 1 - (c - 1) / SH];
        end else if (c == COLS * SH + 1) begin
            v[5] = 1'b1;
        end else if (c == COLS * SH + 3) begin
            v[4] = 1'b1;
            v[3] = 1'b1;
        end else if (c == W_CYC) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 64 && !bus.cmd_ready; i++) step();
        check({tag, "_ready"}, bus.cmd_ready, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [COLS-1:0] d, input string tag);
        wait_ready(tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        step();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= W_CYC; c++) begin
            check($sformatf("%s_pins_c%0d", tag, c), pins(), exp_wr(c, d));
            check($sformatf("%s_addr_c%0d", tag, c), addr, a);
            if (c < W_CYC) step();
        end
    endtask

    // Read with model latency: r_en at cycle 1, data_valid at 3, rsp_valid from 4.
    // stall: cycles rsp_ready stays low; pend: hold another cmd_valid meanwhile.
    task automatic do_read(input logic [AW-1:0] a, input logic [COLS-1:0] d,
                           input int stall, input bit pend, input string tag);
        logic [7:0] e;
        int         wr_base;
        wait_ready(tag);
        wr_base       = wr_cnt;
        bus.rsp_ready = (stall == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = a;
        step();
        bus.cmd_valid = pend;
        for (int c = 1; c <= 4; c++) begin
            e = (c == 1) ? 8'b0000_0100 : (c == 4) ? 8'b0000_0010 : 8'b0000_0000;
            check($sformatf("%s_pins_c%0d", tag, c), pins(), e);
            if (c < 4) step();
        end
        check({tag, "_rdata"}, bus.rsp_rdata, d);
        check({tag, "_err"}, bus.rsp_err, 1'b0);
        for (int s = 0; s < stall; s++) begin
            step();
            check($sformatf("%s_stall%0d_pins", tag, s), pins(), 8'b0000_0010);
            check($sformatf("%s_stall%0d_rdata", tag, s), bus.rsp_rdata, d);
        end
        bus.rsp_ready = 1'b1;
        step();
        check({tag, "_done"}, pins(), 8'b0000_0001);
        bus.cmd_valid = 1'b0;
        check({tag, "_no_wr_done"}, wr_cnt - wr_base, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_base;
        int last_acc;
        int r;
        int seen;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("reset_pins", pins(), 8'h00);
        check("reset_addr", addr, 0);
        check("reset_rdata", bus.rsp_rdata, 0);
        check("reset_err", bus.rsp_err, 0);
        arst_n = 1'b1;

        // Write 8'hA5 to row 3, then read it back through the SRAM model
        do_write(3, 8'hA5, "wr_a5");
        do_read(3, 8'hA5, 0, 1'b0, "rd_a5");

        // Read preloaded row 5, then the same read with a 5-cycle response stall
        do_read(5, 8'h3C, 0, 1'b0, "rd5");
        do_read(5, 8'h3C, 5, 1'b1, "rd5_stall");

        // Back-to-back writes with cmd_valid held high, then read every row
        wait_ready("wr_all");
        wr_base       = wr_cnt;
        last_acc      = -1;
        r             = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < ROWS * W_CYC + 50 && r < ROWS; i++) begin
            if (bus.cmd_ready) begin
                if (r > 0) check($sformatf("wr_all_spacing%0d", r), cyc - last_acc, W_CYC);
                last_acc = cyc;
                r++;
                step();
                if (r < ROWS) begin
                    bus.cmd_addr  = AW'(r);
                    bus.cmd_wdata = COLS'(r);
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end else begin
                step();
            end
        end
        check("wr_all_accepts", r, ROWS);
        wait_ready("wr_all_end");
        check("wr_all_wr_done", wr_cnt - wr_base, ROWS);
        for (int k = 0; k < ROWS; k++)
            do_read(AW'(k), COLS'(k), 0, 1'b0, $sformatf("rd_all%0d", k));

        // Reset asserted at cycle 7 of a write to row 9
        wait_ready("rst_mid");
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 9;
        bus.cmd_wdata = 8'hC3;
        step();
        bus.cmd_valid = 1'b0;
        repeat (6) step();
        check("rst_mid_c7_pins", pins(), exp_wr(7, 8'hC3));
        wr_base = wr_cnt;
        arst_n  = 1'b0;
        #1;
        check("rst_mid_pins", pins(), 8'h00);
        check("rst_mid_addr", addr, 0);
        repeat (2) step();
        arst_n = 1'b1;
        wait_ready("rst_mid_release");
        check("rst_mid_no_wr_done", wr_cnt - wr_base, 0);
        do_write(2, 8'h0F, "wr_0f");
        do_read(2, 8'h0F, 0, 1'b0, "rd_0f");
        do_read(9, 8'h09, 0, 1'b0, "rd9_untouched");

        // Read with data_valid never asserted
        wait_ready("rd_silent");
        mute          = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 1;
        step();
        bus.cmd_valid = 1'b0;
`ifdef SRAM_SEQ_RD_TIMEOUT_EN
        for (int c = 1; c <= RD_TIMEOUT + 1; c++) begin
            check($sformatf("rd_to_valid_c%0d", c), bus.rsp_valid, (c == RD_TIMEOUT + 1));
            if (c <= RD_TIMEOUT) step();
        end
        check("rd_to_err", bus.rsp_err, 1'b1);
        check("rd_to_rdata", bus.rsp_rdata, 8'hFF);
        step();
        mute = 1'b0;
        do_read(1, 8'h01, 0, 1'b0, "rd_after_to");
`else
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid) seen++;
            step();
        end
        check("rd_unbounded_valid", seen, 0);
        check("rd_unbounded_err", bus.rsp_err, 1'b0);
        arst_n = 1'b0;
        repeat (2) step();
        arst_n = 1'b1;
        mute   = 1'b0;
        do_read(1, 8'h01, 0, 1'b0, "rd_after_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_cmd_sequencer.md
Name: sram_cmd_sequencer

Overview:
Upstream driver for the serial-load SRAM top. It accepts parallel read/write commands over a valid/ready handshake and converts each one into the SRAM's pin protocol. A write becomes an MSB-first serial shift, then a load pulse, then a w_en pulse. A read becomes an r_en pulse, a wait for data_valid, and capture of data_out. The block frees the system side from bit-level sequencing and returns read data over a valid/ready response channel.

Parameters:
ROWS, 16, number of SRAM words; address width is $clog2(ROWS)
COLS, 8, word width in bits
SHIFT_HOLD, 2, cycles each serial bit is held with shift=1 (min 1)
RD_TIMEOUT, 16, max cycles to wait for data_valid (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when valid&&ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  $clog2(ROWS)  target row
cmd_wdata  input  COLS  write word
rsp_valid  output  1  read response available
rsp_ready  input  1  response consumed when valid&&ready
rsp_rdata  output  COLS  read word
rsp_err  output  1  read timed out (tied 0 without the optional feature)
wr_done  output  1  one-cycle pulse coincident with w_en
serial_in  output  1  to SRAM serial data
shift  output  1  to SRAM shift enable
load  output  1  to SRAM parallel load
w_en  output  1  to SRAM write enable
r_en  output  1  to SRAM read enable
addr  output  $clog2(ROWS)  to SRAM row address
data_valid  input  1  from SRAM, read data valid
data_out  input  COLS  from SRAM read data

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including rsp_rdata and addr. cmd_ready=0 during reset, 1 in IDLE after reset.
- Asserting reset mid-operation aborts the operation. No wr_done or rsp is produced, and SRAM pins drop to 0 immediately.
- All SRAM-side outputs are registered, so they are glitch-free.
- FSM states: IDLE, SHIFT, LOAD, GAP, WRITE, READ, RD_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_addr into addr and cmd_wdata into the shift buffer.
  - cmd_write=1 goes to SHIFT; cmd_write=0 goes to READ.
  - addr is held stable until the next accept.
- SHIFT:
  - shift=1; serial_in=buffer[COLS-1-k] for bit k=0..COLS-1.
  - Each bit is held SHIFT_HOLD cycles, counted by a bit counter and a hold counter.
  - After COLS*SHIFT_HOLD cycles, go to LOAD.
- LOAD: shift=0, serial_in=0, load=1 for 1 cycle, then GAP.
- GAP: all strobes 0 for 1 cycle, then WRITE.
- WRITE: w_en=1 and wr_done=1 for 1 cycle, then IDLE.
- Write timing: if accept is cycle 0, shift runs cycles 1..COLS*SHIFT_HOLD, load is at COLS*SHIFT_HOLD+1, and w_en is at COLS*SHIFT_HOLD+3. The next accept is possible at COLS*SHIFT_HOLD+4.
- READ:
  - r_en=1 for 1 cycle (cycle 1 after accept).
  - data_valid is sampled from the r_en cycle onward. The first sample seen high captures data_out into rsp_rdata and the FSM goes to RESP.
  - Otherwise go to RD_WAIT.
- RD_WAIT: r_en=0. Wait for data_valid, then capture and go to RESP. Without the feature, the wait is unbounded.
- RESP:
  - rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready.
  - Handshake completes in the cycle valid&&ready; the FSM returns to IDLE.
  - rsp_valid deasserts the next cycle.
- cmd_ready=0 in every state except IDLE, so commands cannot overlap. There is no combinational path from cmd_valid to cmd_ready.
- data_valid outside READ/RD_WAIT is ignored.
- A write never produces rsp_valid; a read never produces wr_done.
- cmd_addr >= ROWS (non-power-of-2 ROWS) is passed through unchanged.

Optional Feature:
- Macro SRAM_SEQ_RD_TIMEOUT_EN.
- Defined:
  - A counter runs from r_en assertion.
  - If data_valid has not been seen within RD_TIMEOUT cycles (r_en cycle counts as 1), go to RESP with rsp_err=1 and rsp_rdata all ones.
  - data_valid arriving in the same cycle the count expires wins: data is captured and rsp_err=0.
  - rsp_err is cleared on the next accept.
- Undefined: no counter is synthesised, rsp_err is constant 0, and RD_WAIT is unbounded.

Test Plan:
- Write addr=3, wdata=8'hA5 (COLS=8, SHIFT_HOLD=2) -> serial_in sequence 1,0,1,0,0,1,0,1, each bit held 2 cycles with shift=1 in cycles 1-16; load at cycle 17; w_en and wr_done at cycle 19; addr=3 throughout; cmd_ready back high at cycle 20.
- Read addr=5, SRAM model returns data_valid with data_out=8'h3C two cycles after r_en -> r_en pulses only at cycle 1; rsp_valid with rsp_rdata=8'h3C, rsp_err=0; no wr_done.
- Same read with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable across all 5 cycles; cmd_ready=0 while a pending cmd_valid is held; completes one cycle after rsp_ready rises.
- Write to every row 0..ROWS-1 back-to-back with cmd_valid held high, data=row index, then read all -> each readback equals its row index; exactly ROWS wr_done pulses; minimum spacing of COLS*SHIFT_HOLD+4 cycles between accepts.
- arst_n pulsed low at cycle 7 of a write -> shift, serial_in, load, w_en all 0 immediately; no wr_done; after release, cmd_ready=1 and a fresh write of 8'h0F completes correctly.
- With SRAM_SEQ_RD_TIMEOUT_EN and RD_TIMEOUT=16, read with data_valid never asserted -> rsp_valid after 16 cycles with rsp_err=1 and rsp_rdata=8'hFF. Without the macro, the same read leaves rsp_valid=0 indefinitely and rsp_err=0.
